// File: rtl/ldu_pkg.sv
// Shared types for the load buffer unit: entry states, entry record and pointer sizing.
package ldu_pkg;

  localparam int unsigned LduDataW = 32;
  localparam int unsigned LduAddrW = 12;
  localparam int unsigned LduTagW  = 3;

  typedef enum logic [1:0] {
    StFree,
    StAddr,
    StPend,
    StDone
  } ldu_state_e;

  typedef struct packed {
    logic [LduTagW-1:0]  tag;
    logic [LduAddrW-1:0] addr;
    logic [LduDataW-1:0] data;
    logic                exc;
  } ldu_entry_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ldu_drop_counter.sv
// Counts memory responses still owed to loads that a flush squashed; they are discarded on arrival.
module ldu_drop_counter #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [CntW-1:0] add_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW:0]   sum;

  always_comb begin
    cnt_d = cnt_q;
    sum   = '0;
    if (dec_i && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    if (flush_i) begin
      sum   = {1'b0, cnt_d} + {1'b0, add_i};
      // Saturate rather than wrap so busy can never falsely drop.
      cnt_d = sum[CntW] ? '1 : sum[CntW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/load_buffer_unit.sv
// In-order Tomasulo load buffer: address generation, pipelined memory reads, CDB broadcast.
// Optional misaligned-load trap enabled by defining LDU_MISALIGN_CHK_EN.
module load_buffer_unit
  import ldu_pkg::*;
#(
  parameter int unsigned DATA_W = LduDataW,
  parameter int unsigned ADDR_W = LduAddrW,
  parameter int unsigned TAG_W  = LduTagW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk1_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [DATA_W-1:0] issue_base_i,
  input  logic [ADDR_W-1:0] issue_offset_i,
  input  logic [TAG_W-1:0]  issue_tag_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  output logic              cdb_valid_o,
  input  logic              cdb_grant_i,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic              cdb_exc_o,
  output logic              busy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  ldu_state_e st_q  [DEPTH];
  ldu_state_e st_d  [DEPTH];
  ldu_entry_t ent_q [DEPTH];
  ldu_entry_t ent_d [DEPTH];

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic              full;
  logic              issue_fire, req_fire, grant_fire;
  logic              resp_to_pend, drop_active;
  logic [ADDR_W-1:0] issue_addr;
  logic              misalign;
  logic              req_found, resp_found;
  logic [PW-1:0]     req_idx, resp_idx;
  logic [CW-1:0]     pend_cnt, drop_add, drop_cnt;

  assign issue_addr = ADDR_W'(issue_base_i + DATA_W'(issue_offset_i));

`ifdef LDU_MISALIGN_CHK_EN
  assign misalign = (issue_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign full          = (cnt_q == CW'(DEPTH));
  assign issue_ready_o = !full;
  assign issue_fire    = issue_valid_i && !full && !flush_i;

  // Walk occupied entries from head so the oldest ADDR/PEND entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    req_found  = 1'b0;
    req_idx    = '0;
    resp_found = 1'b0;
    resp_idx   = '0;
    pend_cnt   = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < cnt_q) begin
        if (!req_found && (st_q[idx] == StAddr)) begin
          req_found = 1'b1;
          req_idx   = idx;
        end
        if (!resp_found && (st_q[idx] == StPend)) begin
          resp_found = 1'b1;
          resp_idx   = idx;
        end
      end
      if (st_q[k] == StPend) pend_cnt = pend_cnt + CW'(1);
    end
  end

  assign mem_req_valid_o = req_found;
  assign mem_req_addr_o  = req_found ? ent_q[req_idx].addr : '0;
  assign req_fire        = req_found && mem_req_ready_i;

  assign cdb_valid_o = (st_q[head_q] == StDone);
  assign cdb_tag_o   = cdb_valid_o ? ent_q[head_q].tag : '0;
  assign cdb_data_o  = cdb_valid_o ? ent_q[head_q].data : '0;
  assign cdb_exc_o   = cdb_valid_o && ent_q[head_q].exc;
  assign grant_fire  = cdb_valid_o && cdb_grant_i;

  assign drop_active  = (drop_cnt != '0);
  assign resp_to_pend = mem_resp_valid_i && !drop_active && resp_found;
  // A request accepted at the flush edge still returns data; a response landing then is paid for.
  assign drop_add     = flush_i ? (pend_cnt + CW'(req_fire) - CW'(resp_to_pend)) : '0;

  assign busy_o = (cnt_q != '0) || drop_active;

  always_comb begin
    st_d    = st_q;
    ent_d   = ent_q;
    alloc_d = alloc_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = StFree;
      alloc_d = '0;
      head_d  = '0;
      cnt_d   = '0;
    end else begin
      if (issue_fire) begin
        ent_d[alloc_q].tag  = issue_tag_i;
        ent_d[alloc_q].addr = issue_addr;
        ent_d[alloc_q].data = '0;
        ent_d[alloc_q].exc  = misalign;
        st_d[alloc_q]       = misalign ? StDone : StAddr;
        alloc_d             = alloc_q + 1'b1;
      end
      if (req_fire) st_d[req_idx] = StPend;
      if (resp_to_pend) begin
        st_d[resp_idx]       = StDone;
        ent_d[resp_idx].data = mem_resp_data_i;
      end
      if (grant_fire) begin
        st_d[head_q] = StFree;
        head_d       = head_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(issue_fire) - CW'(grant_fire);
    end
  end

  always_ff @(posedge clk1_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= StFree;
        ent_q[i] <= '0;
      end
      alloc_q <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= st_d[i];
        ent_q[i] <= ent_d[i];
      end
      alloc_q <= alloc_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
    end
  end

  ldu_drop_counter #(
    .CntW (CW)
  ) u_drop_counter (
    .clk_i   (clk1_i),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .add_i   (drop_add),
    .dec_i   (mem_resp_valid_i && drop_active),
    .cnt_o   (drop_cnt)
  );

endmodule
